sram_dp_rw: RTL

//  Parametrised simple-dual-port synchronous SRAM: one write port and one read port sharing one clock.

---
 rtl/sram_dp_rw.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sram_dp_rw.sv
// Simple-dual-port synchronous SRAM with per-lane write enables, write-first collision
// forwarding and a clear sweep after reset. Optional macro SRAM_OUT_REG_EN adds an output stage.
//   state    | meaning
//   ST_IDLE  | ports active, clear_i sampled
//   ST_CLEAR | sweeping CLEAR_VALUE into mem_q[clr_addr_q], ports locked out
module sram_dp_rw #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int NLANES = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NLANES-1:0]     wr_lane_en_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lanes
        $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                    clr_we;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    busy;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   wr_merged;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    assign busy    = (state_q == ST_CLEAR);
    assign busy_o  = busy;
    assign wr_fire = wr_en_i & ~busy;
    assign rd_fire = rd_en_i & ~busy;

    // Word as it will look after this edge's write; doubles as the write-first read result.
    always_comb begin
        wr_merged = mem_q[wr_addr_i];
        for (int l = 0; l < NLANES; l++) begin
            if (wr_lane_en_i[l]) begin
                wr_merged[l*LANE_WIDTH +: LANE_WIDTH] = wdata_i[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    assign rd_word = (wr_fire && (wr_addr_i == rd_addr_i)) ? wr_merged : mem_q[rd_addr_i];

    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[clr_addr_q] <= CLEAR_VALUE;
        end else if (wr_fire) begin
            for (int l = 0; l < NLANES; l++) begin
                if (wr_lane_en_i[l]) begin
                    mem_q[wr_addr_i][l*LANE_WIDTH +: LANE_WIDTH] <= wdata_i[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rdata_d  = rd_fire ? rd_word : rdata_q;
        rvalid_d = rd_fire;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] rdata_out_q, rdata_out_d;
    logic                  rvalid_out_q, rvalid_out_d;

    // A read still in flight when a sweep starts is dropped along with the port lockout.
    always_comb begin
        rvalid_out_d = rvalid_q & ~busy;
        rdata_out_d  = rvalid_out_d ? rdata_q : rdata_out_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_out_q  <= '0;
            rvalid_out_q <= 1'b0;
        end else begin
            rdata_out_q  <= rdata_out_d;
            rvalid_out_q <= rvalid_out_d;
        end
    end

    assign rdata_o  = rdata_out_q;
    assign rvalid_o = rvalid_out_q;
`else
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
`endif

endmodule
